// File: rtl/shift_sequencer_if.sv
// Request/response bundle for the iterative shift unit: start/op/operand in, busy/done/result out.
interface shift_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int SW    = 5
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] data_in;
  logic [SW-1:0]    shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, data_in, shamt,
    input  busy, done, result
  );

  modport slave (
    input  start, op, data_in, shamt,
    output busy, done, result
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shifter (SRL/SRA/SLL/ROR): one 1-bit step per clock,
// done pulses shamt+1 cycles after the start edge.
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int SW    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_sequencer_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OP_SRL = 2'b00,
    OP_SRA = 2'b01,
    OP_SLL = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_data, w_data_nxt;
  logic [SW-1:0]    r_cnt, w_cnt_nxt;
  op_e              r_op, w_op_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic             r_done, w_done_nxt;
  logic [WIDTH-1:0] w_step;

  // Single 1-bit step of the captured operand under the captured op.
  always_comb begin
    w_step = r_data;
    unique case (r_op)
      OP_SRL: w_step = {1'b0, r_data[WIDTH-1:1]};
      OP_SRA: w_step = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
      OP_SLL: w_step = {r_data[WIDTH-2:0], 1'b0};
      OP_ROR: w_step = {r_data[0], r_data[WIDTH-1:1]};
      default: w_step = r_data;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_data_nxt   = r_data;
    w_cnt_nxt    = r_cnt;
    w_op_nxt     = r_op;
    w_result_nxt = r_result;
    w_done_nxt   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_data_nxt  = bus.data_in;
          w_cnt_nxt   = bus.shamt;
          w_op_nxt    = op_e'(bus.op);
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt != '0) begin
          w_data_nxt = w_step;
          w_cnt_nxt  = r_cnt - SW'(1);
        end else begin
          w_result_nxt = r_data;
          w_done_nxt   = 1'b1;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_data   <= '0;
      r_cnt    <= '0;
      r_op     <= OP_SRL;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_data   <= w_data_nxt;
      r_cnt    <= w_cnt_nxt;
      r_op     <= w_op_nxt;
      r_result <= w_result_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign bus.busy   = (r_state == SHIFT);
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: latency, busy width, op results, handshake and reset abort.
module tb_shift_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  shift_sequencer_if #(.WIDTH(32), .SW(5)) sif ();

  shift_sequencer #(.WIDTH(32), .SW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives start on that negedge so the next posedge is E0.
  // Scrambles the inputs after acceptance; optionally re-pokes start during busy.
  task automatic do_req(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh,
                        input bit poke, output logic [31:0] res, output int lat,
                        output int bcnt, output bit stable);
    logic [31:0] held;
    held         = sif.result;
    sif.start    = 1'b1;
    sif.op       = op;
    sif.data_in  = d;
    sif.shamt    = sh;
    lat          = 0;
    bcnt         = 0;
    stable       = 1'b1;
    @(negedge clk);
    sif.start    = poke;
    sif.data_in  = ~d;
    sif.shamt    = sh ^ 5'h15;
    sif.op       = ~op;
    for (int k = 1; k <= 40; k++) begin
      if (sif.busy) bcnt++;
      if (sif.result !== held) stable = 1'b0;
      @(negedge clk);
      sif.start = 1'b0;
      if (sif.done) begin
        lat = k;
        break;
      end
    end
    res = sif.result;
  endtask

  logic [31:0] res;
  int          lat;
  int          bcnt;
  bit          stable;
  int          stray;

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    sif.start   = 1'b0;
    sif.op      = 2'b00;
    sif.data_in = '0;
    sif.shamt   = '0;

    #23;
    chk("reset_busy",   {31'b0, sif.busy}, 32'h0);
    chk("reset_done",   {31'b0, sif.done}, 32'h0);
    chk("reset_result", sif.result,        32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // SRA of negative operand, then a back-to-back request issued in the done cycle
    do_req(2'b01, 32'h8000_0000, 5'd4, 1'b0, res, lat, bcnt, stable);
    chk("sra_neg_result",  res,         32'hF800_0000);
    chk("sra_neg_latency", 32'(lat),    32'd5);
    chk("sra_neg_busy",    32'(bcnt),   32'd5);
    chk("sra_neg_done_busy_low", {31'b0, sif.busy}, 32'h0);
    do_req(2'b01, 32'h4000_0000, 5'd4, 1'b0, res, lat, bcnt, stable);
    chk("b2b_result",  res,            32'h0400_0000);
    chk("b2b_latency", 32'(lat),       32'd5);
    chk("b2b_held",    {31'b0, stable}, 32'h1);
    @(negedge clk);
    chk("done_one_cycle", {31'b0, sif.done}, 32'h0);
    chk("result_held",    sif.result,        32'h0400_0000);

    do_req(2'b00, 32'h8000_0000, 5'd31, 1'b0, res, lat, bcnt, stable);
    chk("srl31_result",  res,       32'h0000_0001);
    chk("srl31_latency", 32'(lat),  32'd32);
    chk("srl31_busy",    32'(bcnt), 32'd32);

    do_req(2'b10, 32'h0000_0001, 5'd0, 1'b0, res, lat, bcnt, stable);
    chk("sll0_result",  res,       32'h0000_0001);
    chk("sll0_latency", 32'(lat),  32'd1);
    chk("sll0_busy",    32'(bcnt), 32'd1);

    do_req(2'b11, 32'h0000_0001, 5'd1, 1'b0, res, lat, bcnt, stable);
    chk("ror1_result", res, 32'h8000_0000);

    // start re-asserted with different data while busy must be dropped
    do_req(2'b11, 32'h1234_5678, 5'd8, 1'b1, res, lat, bcnt, stable);
    chk("ror8_poke_result",  res,      32'h7812_3456);
    chk("ror8_poke_latency", 32'(lat), 32'd9);
    @(negedge clk);
    chk("poke_no_extra_busy", {31'b0, sif.busy}, 32'h0);

    do_req(2'b11, 32'h0000_0001, 5'd31, 1'b0, res, lat, bcnt, stable);
    chk("ror31_result", res, 32'h0000_0002);

    do_req(2'b10, 32'h0000_0003, 5'd30, 1'b0, res, lat, bcnt, stable);
    chk("sll30_result", res, 32'hC000_0000);

    // abort a long request with an asynchronous reset mid-cycle
    sif.start   = 1'b1;
    sif.op      = 2'b00;
    sif.data_in = 32'h8000_0000;
    sif.shamt   = 5'd31;
    @(negedge clk);
    sif.start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy",   {31'b0, sif.busy}, 32'h0);
    chk("abort_done",   {31'b0, sif.done}, 32'h0);
    chk("abort_result", sif.result,        32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(2'b10, 32'h0000_0001, 5'd4, 1'b0, res, lat, bcnt, stable);
    chk("post_reset_result",  res,      32'h0000_0010);
    chk("post_reset_latency", 32'(lat), 32'd5);
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (sif.done) stray++;
    end
    chk("no_stray_done", 32'(stray), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift controller that drives a single-bit shift stage iteratively to perform a 32-bit shift by 0–31 positions. It accepts one request at a time over a start/busy/done handshake. It sequences one 1-bit step per clock until the requested amount is consumed. It sits beside the ALU as the shift unit for SRL, SRA, SLL and ROR, trading latency for a minimal 1-bit datapath.

## Interface
- WIDTH, 32: data width; fixed at 32 for this revision.
- SW, 5: shift-amount width; equals log2(WIDTH).

- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  2  operation: 00 SRL, 01 SRA, 10 SLL, 11 ROR.
- data_in  input  WIDTH  operand; captured when start is accepted.
- shamt  input  SW  shift amount 0–31; captured when start is accepted.
- busy  output  1  high while a request is in progress.
- done  output  1  one-cycle pulse when result becomes valid.
- result  output  WIDTH  shifted value; held until the next done.

## Operation
- Internal state:
  - data_q[31:0]
  - cnt_q[4:0]
  - op_q[1:0]
  - FSM with two states, IDLE and SHIFT.
- IDLE:
  - busy=0.
  - If start=1 at a rising edge: data_q←data_in, cnt_q←shamt, op_q←op, go to SHIFT.
  - If start=0: stay in IDLE.
- SHIFT with cnt_q≠0: apply one 1-bit step to data_q per edge and decrement cnt_q. Steps by op_q:
  - SRL: {1'b0, d[31:1]}
  - SRA: {d[31], d[31:1]}
  - SLL: {d[30:0], 1'b0}
  - ROR: {d[0], d[31:1]}
- SHIFT with cnt_q=0: result←data_q, assert done for the following cycle, return to IDLE.
- busy=1 exactly while the FSM is in SHIFT.
- start is ignored while busy=1. No queueing; a dropped request gives no error indication.
- data_in, shamt and op may change freely after acceptance; only the captured copies are used.
- Arithmetic rules:
  - SRA replicates bit 31 captured at acceptance on every step.
  - ROR by n equals a rotate right by n mod 32; shamt=0 returns data_in unchanged.
- result changes only on the edge that raises done.

## Timing
- Reset (rst_n=0, asynchronous, any state):
  - FSM→IDLE.
  - busy=0, done=0, result=32'h0.
  - data_q, cnt_q, op_q=0.
- Reset asserted mid-operation aborts the request with no done. After release the block accepts start on the first edge.
- Let the start-acceptance edge be E0. Edges E1…E(shamt) perform the shifts. Edge E(shamt+1) loads result and raises done.
- Latency from start edge to done edge: shamt+1 cycles. Minimum is 1 (shamt=0); maximum is 32 (shamt=31).
- busy rises after E0 and falls after E(shamt+1), in the same cycle done rises.
- done is high for exactly one cycle.
- A new start may be asserted in the done cycle: the block is in IDLE and accepts it. Back-to-back requests therefore have a throughput of one request per shamt+2 cycles.
- Simultaneous start and done: accepted. The new result does not overwrite the held result until its own done.

## Test plan
- Reset: hold rst_n=0 mid-SHIFT, then release → busy=0, done=0, result=0 immediately; no stray done afterwards.
- SRA: data_in=0x80000000, shamt=4 → done 5 cycles after start, result=0xF8000000; busy high for exactly 5 cycles.
- SRL: data_in=0x80000000, shamt=31 → done after 32 cycles, result=0x00000001.
- SLL and ROR:
  - SLL 0x00000001 by 0 → done after 1 cycle, result=0x00000001.
  - ROR 0x00000001 by 1 → result=0x80000000.
  - ROR 0x12345678 by 8 → result=0x78123456.
- Handshake:
  - start re-asserted while busy with different data → ignored; the first result is unchanged.
  - start in the done cycle → second request accepted; its done arrives shamt+1 cycles later.
  - Inputs changed after acceptance → no effect on the result.
